// File: rtl/ctrl_alu_pkg.sv
// Shared definitions for the control-op lane ALU: opcodes, flag bit
// positions and the fetch-redirect state encoding.
package ctrl_alu_pkg;

   // Control-op opcodes as presented on opcode_i
   localparam logic [7:0] OP_JUMP   = 8'h02;
   localparam logic [7:0] OP_JAL    = 8'h03;
   localparam logic [7:0] OP_BEQ    = 8'h04;
   localparam logic [7:0] OP_BNE    = 8'h05;
   localparam logic [7:0] OP_BLEZ   = 8'h06;
   localparam logic [7:0] OP_BGTZ   = 8'h07;
   localparam logic [7:0] OP_JR     = 8'h08;
   localparam logic [7:0] OP_JALR   = 8'h09;
   localparam logic [7:0] OP_BLTZ   = 8'h10;
   localparam logic [7:0] OP_BGEZ   = 8'h11;
   localparam logic [7:0] OP_BLTZAL = 8'h12;
   localparam logic [7:0] OP_BGEZAL = 8'h13;
   localparam logic [7:0] OP_BC1F   = 8'h20;
   localparam logic [7:0] OP_BC1T   = 8'h21;

   // Bit positions inside the 8-bit execution flag vector
   localparam int FLAG_EXEC = 7;
   localparam int FLAG_COND = 5;
   localparam int FLAG_LINK = 4;
   localparam int FLAG_CTRL = 2;
   localparam int FLAG_EXC  = 1;
   localparam int FLAG_MISP = 0;

   // Legacy flag pattern reported for FP-condition branches
   localparam logic [7:0] FLAGS_BC1 = 8'h14;

   typedef enum logic {
      IDLE  = 1'b0,
      REDIR = 1'b1
   } redir_state_t;

endpackage

// File: rtl/ctrl_alu_resolve.sv
// Purely combinational resolver: computes direction, next PC, link result
// and execution flags for one control op held in pipeline stage 1.
module ctrl_alu_resolve #(
   parameter int DATA_W     = 32,
   parameter int PC_W       = 32,
   parameter int IMM_W      = 16,
   parameter int TARGET_W   = 26,
   parameter bit LINK_BR_EN = 1'b1
) (
   input  logic [7:0]        opcode_i,
   input  logic [DATA_W-1:0] data1_i,
   input  logic [DATA_W-1:0] data2_i,
   input  logic [IMM_W-1:0]  immd_i,
   input  logic [PC_W-1:0]   pred_target_i,
   input  logic              pred_dir_i,
   input  logic [PC_W-1:0]   pc_i,
   output logic              direction_o,
   output logic [PC_W-1:0]   next_pc_o,
   output logic [PC_W-1:0]   result_o,
   output logic [7:0]        flags_o
);
   import ctrl_alu_pkg::*;

   logic [PC_W-1:0] simm;
   logic [PC_W-1:0] fall_pc;
   logic [PC_W-1:0] taken_pc;
   logic [PC_W-1:0] j_target;
   logic [PC_W-1:0] d1_pc;
   logic            d1_neg;
   logic            d1_zero;

   // Address arithmetic; all sums wrap modulo 2^PC_W
   assign simm     = PC_W'($signed(immd_i)) << 2;
   assign fall_pc  = pc_i + PC_W'(8);
   assign taken_pc = fall_pc + simm;
   // Region bits come from the PC; TARGET_W must equal PC_W-6
   assign j_target = {pc_i[PC_W-1:PC_W-4], pred_target_i[TARGET_W-1:0], 2'b00};
   assign d1_pc    = PC_W'(data1_i);
   assign d1_neg   = data1_i[DATA_W-1];
   assign d1_zero  = (data1_i == '0);

   logic known;
   logic is_cond;
   logic is_link;
   logic is_jr;

   // Decode the op, resolve direction/target and assemble the flag vector
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      direction_o = 1'b0;
      next_pc_o   = '0;
      result_o    = '0;
      flags_o     = '0;
      known       = 1'b1;
      is_cond     = 1'b0;
      is_link     = 1'b0;
      is_jr       = 1'b0;
      case (opcode_i)
         OP_JUMP: begin direction_o = 1'b1; next_pc_o = j_target; end
         OP_JAL:  begin direction_o = 1'b1; next_pc_o = j_target; is_link = 1'b1; end
         OP_JR:   begin direction_o = 1'b1; next_pc_o = d1_pc; is_jr = 1'b1; end
         OP_JALR: begin direction_o = 1'b1; next_pc_o = d1_pc; is_jr = 1'b1; is_link = 1'b1; end
         OP_BEQ:  begin is_cond = 1'b1; direction_o = (data1_i == data2_i); end
         OP_BNE:  begin is_cond = 1'b1; direction_o = (data1_i != data2_i); end
         OP_BLEZ: begin is_cond = 1'b1; direction_o = d1_neg | d1_zero; end
         OP_BGTZ: begin is_cond = 1'b1; direction_o = !d1_neg & !d1_zero; end
         OP_BLTZ: begin is_cond = 1'b1; direction_o = d1_neg; end
         OP_BGEZ: begin is_cond = 1'b1; direction_o = !d1_neg; end
         // Linking branches collapse to an all-zero no-op when disabled
         OP_BLTZAL: begin
            if (LINK_BR_EN) begin is_cond = 1'b1; is_link = 1'b1; direction_o = d1_neg; end
            else known = 1'b0;
         end
         OP_BGEZAL: begin
            if (LINK_BR_EN) begin is_cond = 1'b1; is_link = 1'b1; direction_o = !d1_neg; end
            else known = 1'b0;
         end
         // FP-condition branches are not resolved here; they only carry the
         // legacy flag pattern (executed bit left clear) and a zero next PC
         OP_BC1F, OP_BC1T: begin known = 1'b0; flags_o = FLAGS_BC1; end
         default: known = 1'b0;
      endcase

      if (is_cond) next_pc_o = direction_o ? taken_pc : fall_pc;

      if (known) begin
         flags_o[FLAG_EXEC] = 1'b1;
         flags_o[FLAG_COND] = is_cond;
         flags_o[FLAG_LINK] = is_link;
         flags_o[FLAG_CTRL] = 1'b1;
         flags_o[FLAG_EXC]  = 1'b0;
         if (is_jr)
            flags_o[FLAG_MISP] = (d1_pc != pred_target_i);
         else if (is_cond)
            flags_o[FLAG_MISP] = (direction_o != pred_dir_i) ||
                                 (direction_o && (pred_target_i != taken_pc));
         if (is_link) result_o = fall_pc;
      end
   end

endmodule

// File: rtl/ctrl_alu_pipe.sv
// Two-stage valid/ready control-op ALU with mispredict detection and a
// held fetch-redirect request that squashes younger work until acknowledged.
module ctrl_alu_pipe #(
   parameter int DATA_W     = 32,
   parameter int PC_W       = 32,
   parameter int IMM_W      = 16,
   parameter int TARGET_W   = 26,
   parameter int TAG_W      = 6,
   parameter bit LINK_BR_EN = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] data1_i,
   input  logic [DATA_W-1:0] data2_i,
   input  logic [IMM_W-1:0]  immd_i,
   input  logic [7:0]        opcode_i,
   input  logic [PC_W-1:0]   predictedTarget_i,
   input  logic              predictedDir_i,
   input  logic [PC_W-1:0]   pc_i,
   input  logic [TAG_W-1:0]  tag_i,
   input  logic              flush_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [PC_W-1:0]   result_o,
   output logic [PC_W-1:0]   nextPC_o,
   output logic              direction_o,
   output logic [7:0]        flags_o,
   output logic [TAG_W-1:0]  tag_o,
   output logic              redirect_valid_o,
   output logic [PC_W-1:0]   redirect_pc_o,
   input  logic              redirect_ack_i
);
   import ctrl_alu_pkg::*;

   redir_state_t state_q, state_d;

   logic              s1_valid;
   logic [7:0]        s1_op;
   logic [DATA_W-1:0] s1_d1, s1_d2;
   logic [IMM_W-1:0]  s1_immd;
   logic [PC_W-1:0]   s1_pt, s1_pc;
   logic              s1_pd;
   logic [TAG_W-1:0]  s1_tag;

   logic              s2_adv;
   logic              mp_fire;
   logic              res_dir;
   logic [PC_W-1:0]   res_next, res_result;
   logic [7:0]        res_flags;

   assign s2_adv = !out_valid_o || out_ready_i;

   ctrl_alu_resolve #(
      .DATA_W(DATA_W), .PC_W(PC_W), .IMM_W(IMM_W),
      .TARGET_W(TARGET_W), .LINK_BR_EN(LINK_BR_EN)
   ) u_resolve (
      .opcode_i     (s1_op),
      .data1_i      (s1_d1),
      .data2_i      (s1_d2),
      .immd_i       (s1_immd),
      .pred_target_i(s1_pt),
      .pred_dir_i   (s1_pd),
      .pc_i         (s1_pc),
      .direction_o  (res_dir),
      .next_pc_o    (res_next),
      .result_o     (res_result),
      .flags_o      (res_flags)
   );

   // Redirect FSM next state, input backpressure and redirect request
   always_comb begin
      state_d          = state_q;
      in_ready_o       = 1'b0;
      redirect_valid_o = 1'b0;
      mp_fire          = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready_o = !s1_valid || s2_adv;
            if (out_valid_o && out_ready_i && flags_o[FLAG_MISP] && !flush_i) begin
               mp_fire = 1'b1;
               state_d = REDIR;
            end
         end
         REDIR: begin
            redirect_valid_o = 1'b1;
            if (redirect_ack_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (flush_i) state_d = IDLE;
   end

   // State register and held redirect PC
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         redirect_pc_o <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so every
         // register samples pre-edge values regardless of block order.
         state_q <= state_d;
         if (mp_fire)               redirect_pc_o <= nextPC_o;
         else if (state_d == IDLE)  redirect_pc_o <= '0;
      end
   end

   // Stage 1: capture accepted instructions; drop wrong-path work on redirect
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_op    <= '0;
         s1_d1    <= '0;
         s1_d2    <= '0;
         s1_immd  <= '0;
         s1_pt    <= '0;
         s1_pd    <= 1'b0;
         s1_pc    <= '0;
         s1_tag   <= '0;
      end else if (flush_i || mp_fire || state_q == REDIR) begin
         s1_valid <= 1'b0;
      end else if (in_valid_i && in_ready_o) begin
         s1_valid <= 1'b1;
         s1_op    <= opcode_i;
         s1_d1    <= data1_i;
         s1_d2    <= data2_i;
         s1_immd  <= immd_i;
         s1_pt    <= predictedTarget_i;
         s1_pd    <= predictedDir_i;
         s1_pc    <= pc_i;
         s1_tag   <= tag_i;
      end else if (s2_adv) begin
         s1_valid <= 1'b0;
      end
   end

   // Stage 2: register resolved results; the entry behind a mispredict is squashed
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_o <= 1'b0;
         result_o    <= '0;
         nextPC_o    <= '0;
         direction_o <= 1'b0;
         flags_o     <= '0;
         tag_o       <= '0;
      end else if (flush_i || mp_fire) begin
         out_valid_o <= 1'b0;
         result_o    <= '0;
         nextPC_o    <= '0;
         direction_o <= 1'b0;
         flags_o     <= '0;
         tag_o       <= '0;
      end else if (s2_adv) begin
         out_valid_o <= s1_valid;
         if (s1_valid) begin
            result_o    <= res_result;
            nextPC_o    <= res_next;
            direction_o <= res_dir;
            flags_o     <= res_flags;
            tag_o       <= s1_tag;
         end
      end
   end

endmodule

// File: tb/tb_ctrl_alu_pipe.sv
// Scoreboard bench for ctrl_alu_pipe: directed scenarios push hand-derived
// expectations on accept; a monitor pops and compares on each transfer.
module tb_ctrl_alu_pipe;
   import ctrl_alu_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid_i = 1'b0;
   logic        in_ready_o;
   logic [31:0] data1_i = '0, data2_i = '0;
   logic [15:0] immd_i = '0;
   logic [7:0]  opcode_i = '0;
   logic [31:0] predictedTarget_i = '0;
   logic        predictedDir_i = 1'b0;
   logic [31:0] pc_i = '0;
   logic [5:0]  tag_i = '0;
   logic        flush_i = 1'b0;
   logic        out_valid_o;
   logic        out_ready_i = 1'b1;
   logic [31:0] result_o, nextPC_o;
   logic        direction_o;
   logic [7:0]  flags_o;
   logic [5:0]  tag_o;
   logic        redirect_valid_o;
   logic [31:0] redirect_pc_o;
   logic        redirect_ack_i = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic [5:0]  tag;
      logic [31:0] result;
      logic [31:0] next_pc;
      logic        dir;
      logic [7:0]  flags;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   always #5 clk = ~clk;

   ctrl_alu_pipe dut (
      .clk(clk), .reset(reset),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .data1_i(data1_i), .data2_i(data2_i), .immd_i(immd_i), .opcode_i(opcode_i),
      .predictedTarget_i(predictedTarget_i), .predictedDir_i(predictedDir_i),
      .pc_i(pc_i), .tag_i(tag_i), .flush_i(flush_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .result_o(result_o), .nextPC_o(nextPC_o), .direction_o(direction_o),
      .flags_o(flags_o), .tag_o(tag_o),
      .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
      .redirect_ack_i(redirect_ack_i)
   );

   // Monitor: every transfer must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (!reset && out_valid_o && out_ready_i) begin
         n_tests++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_output tag=%0d next=%h flags=%h (no result expected)",
                     tag_o, nextPC_o, flags_o);
         end else begin
            mon_e = sb.pop_front();
            if (tag_o !== mon_e.tag || result_o !== mon_e.result || nextPC_o !== mon_e.next_pc ||
                direction_o !== mon_e.dir || flags_o !== mon_e.flags) begin
               n_fail++;
               $display("FAIL result tag=%0d res=%h next=%h dir=%b flags=%h expected tag=%0d res=%h next=%h dir=%b flags=%h",
                        tag_o, result_o, nextPC_o, direction_o, flags_o,
                        mon_e.tag, mon_e.result, mon_e.next_pc, mon_e.dir, mon_e.flags);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Present one instruction until accepted; record its expectation if push
   task automatic send(input logic [7:0] op, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [15:0] immd, input logic [31:0] pt, input logic pd,
                       input logic [31:0] pc, input logic [5:0] tag, input bit push,
                       input logic [31:0] e_res, input logic [31:0] e_next,
                       input logic e_dir, input logic [7:0] e_flags);
      int   cnt;
      logic acc;
      exp_t e;
      opcode_i = op; data1_i = d1; data2_i = d2; immd_i = immd;
      predictedTarget_i = pt; predictedDir_i = pd; pc_i = pc; tag_i = tag;
      in_valid_i = 1'b1;
      cnt = 0;
      acc = 1'b0;
      while (!acc && cnt < 50) begin
         @(negedge clk);
         acc = in_ready_o;
         @(posedge clk);
         #1;
         cnt++;
      end
      in_valid_i = 1'b0;
      n_tests++;
      if (!acc) begin
         n_fail++;
         $display("FAIL send_timeout tag=%0d in_ready=%b required 1 within 50 cycles", tag, in_ready_o);
      end else if (push) begin
         e.tag = tag; e.result = e_res; e.next_pc = e_next; e.dir = e_dir; e.flags = e_flags;
         sb.push_back(e);
      end
   endtask

   task automatic wait_drain();
      int cnt;
      cnt = 0;
      while (sb.size() != 0 && cnt < 200) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      repeat (2) begin @(posedge clk); #1; end
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain_timeout outstanding=%0d required 0", sb.size());
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || redirect_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl in_ready=%b out_valid=%b redir=%b required 1 0 0",
                  in_ready_o, out_valid_o, redirect_valid_o);
      end
      n_tests++;
      if (result_o !== 32'h0 || nextPC_o !== 32'h0 || flags_o !== 8'h0 || tag_o !== 6'h0 ||
          direction_o !== 1'b0 || redirect_pc_o !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_data res=%h next=%h flags=%h tag=%0d dir=%b rpc=%h required all 0",
                  result_o, nextPC_o, flags_o, tag_o, direction_o, redirect_pc_o);
      end
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_bgez_latency();
      out_ready_i = 1'b1;
      send(OP_BGEZ, 32'h0, 32'h0, 16'h0004, 32'h1018, 1'b1, 32'h1000, 6'd1, 1'b1,
           32'h0, 32'h1018, 1'b1, 8'hA4);
      n_tests++;
      if (out_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL latency_early out_valid=%b required 0 one edge after accept", out_valid_o);
      end
      @(posedge clk);
      #1;
      n_tests++;
      if (out_valid_o !== 1'b1) begin
         n_fail++;
         $display("FAIL latency out_valid=%b required 1 two edges after accept", out_valid_o);
      end
      wait_drain();
      n_tests++;
      if (redirect_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL bgez_no_redirect redirect_valid=%b required 0", redirect_valid_o);
      end
   endtask

   task automatic test_jumps();
      out_ready_i = 1'b1;
      send(OP_JALR, 32'h8000, 32'h0, 16'h0, 32'h8000, 1'b1, 32'h400, 6'd2, 1'b1,
           32'h408, 32'h8000, 1'b1, 8'h94);
      send(OP_JAL, 32'h0, 32'h0, 16'h0, 32'h0000_0123, 1'b1, 32'h3000_0000, 6'd3, 1'b1,
           32'h3000_0008, 32'h3000_048C, 1'b1, 8'h94);
      wait_drain();
      n_tests++;
      if (redirect_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL jump_no_redirect redirect_valid=%b required 0", redirect_valid_o);
      end
   endtask

   task automatic test_misc_ops();
      out_ready_i = 1'b1;
      send(OP_BLTZAL, 32'hFFFF_FFFF, 32'h0, 16'h0001, 32'h50C, 1'b1, 32'h500, 6'd4, 1'b1,
           32'h508, 32'h50C, 1'b1, 8'hB4);
      send(OP_BGEZAL, 32'hFFFF_FFFF, 32'h0, 16'h0001, 32'h0, 1'b0, 32'h500, 6'd5, 1'b1,
           32'h508, 32'h508, 1'b0, 8'hB4);
      send(OP_BC1T, 32'h1, 32'h1, 16'h0004, 32'h0, 1'b0, 32'h600, 6'd6, 1'b1,
           32'h0, 32'h0, 1'b0, 8'h14);
      send(8'hFF, 32'h1, 32'h2, 16'h0004, 32'h0, 1'b0, 32'h700, 6'd7, 1'b1,
           32'h0, 32'h0, 1'b0, 8'h00);
      wait_drain();
   endtask

   task automatic test_mispredict_redirect();
      out_ready_i = 1'b1;
      send(OP_BEQ, 32'd5, 32'd5, 16'h0010, 32'h2000, 1'b1, 32'h1000, 6'd8, 1'b1,
           32'h0, 32'h1048, 1'b1, 8'hA5);
      // Younger wrong-path instruction: must never reach the output
      send(OP_BNE, 32'd1, 32'd2, 16'h0, 32'h0, 1'b0, 32'h1004, 6'd9, 1'b0,
           32'h0, 32'h0, 1'b0, 8'h0);
      @(posedge clk);
      #1;
      n_tests++;
      if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h1048 || in_ready_o !== 1'b0 ||
          out_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL redirect_enter rv=%b rpc=%h in_ready=%b out_valid=%b required 1 00001048 0 0",
                  redirect_valid_o, redirect_pc_o, in_ready_o, out_valid_o);
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         n_tests++;
         if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h1048 || out_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL redirect_hold cycle=%0d rv=%b rpc=%h out_valid=%b required 1 00001048 0",
                     i, redirect_valid_o, redirect_pc_o, out_valid_o);
         end
      end
      redirect_ack_i = 1'b1;
      @(posedge clk);
      #1;
      redirect_ack_i = 1'b0;
      n_tests++;
      if (redirect_valid_o !== 1'b0 || in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL redirect_ack rv=%b in_ready=%b out_valid=%b required 0 1 0",
                  redirect_valid_o, in_ready_o, out_valid_o);
      end
      wait_drain();
   endtask

   task automatic test_back_to_back();
      out_ready_i = 1'b0;
      fork
         begin
            send(OP_JUMP, 32'h0, 32'h0, 16'h0, 32'h40, 1'b1, 32'h100, 6'd0, 1'b1,
                 32'h0, 32'h100, 1'b1, 8'h84);
            send(OP_BNE, 32'd1, 32'd2, 16'hFFFF, 32'h204, 1'b1, 32'h200, 6'd1, 1'b1,
                 32'h0, 32'h204, 1'b1, 8'hA4);
            send(OP_BLEZ, 32'h8000_0000, 32'h0, 16'h0002, 32'h310, 1'b1, 32'h300, 6'd2, 1'b1,
                 32'h0, 32'h310, 1'b1, 8'hA4);
            send(OP_BGTZ, 32'h0, 32'h0, 16'h0008, 32'h0, 1'b0, 32'h400, 6'd3, 1'b1,
                 32'h0, 32'h408, 1'b0, 8'hA4);
         end
         begin
            repeat (3) @(posedge clk);
            #1;
            n_tests++;
            if (in_ready_o !== 1'b0 || out_valid_o !== 1'b1 || tag_o !== 6'd0) begin
               n_fail++;
               $display("FAIL b2b_stall in_ready=%b out_valid=%b tag=%0d required 0 1 0",
                        in_ready_o, out_valid_o, tag_o);
            end
            out_ready_i = 1'b1;
         end
      join
      wait_drain();
   endtask

   task automatic test_flush();
      out_ready_i = 1'b1;
      // Mispredict transferring together with flush: no redirect
      send(OP_BEQ, 32'd5, 32'd5, 16'h0010, 32'h2000, 1'b1, 32'h1000, 6'd20, 1'b1,
           32'h0, 32'h1048, 1'b1, 8'hA5);
      @(posedge clk);
      #1;
      flush_i = 1'b1;
      @(posedge clk);
      #1;
      flush_i = 1'b0;
      n_tests++;
      if (redirect_valid_o !== 1'b0 || out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_with_misp rv=%b out_valid=%b in_ready=%b required 0 0 1",
                  redirect_valid_o, out_valid_o, in_ready_o);
      end
      // JR mispredict enters REDIR; flush plus ack together returns to IDLE
      send(OP_JR, 32'h100, 32'h0, 16'h0, 32'h200, 1'b1, 32'h40, 6'd21, 1'b1,
           32'h0, 32'h100, 1'b1, 8'h85);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      n_tests++;
      if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h100) begin
         n_fail++;
         $display("FAIL jr_redirect rv=%b rpc=%h required 1 00000100", redirect_valid_o, redirect_pc_o);
      end
      flush_i = 1'b1;
      redirect_ack_i = 1'b1;
      @(posedge clk);
      #1;
      flush_i = 1'b0;
      redirect_ack_i = 1'b0;
      n_tests++;
      if (redirect_valid_o !== 1'b0 || out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_in_redir rv=%b out_valid=%b in_ready=%b required 0 0 1",
                  redirect_valid_o, out_valid_o, in_ready_o);
      end
      // Flush empties both stages while writeback stalls
      out_ready_i = 1'b0;
      send(OP_JUMP, 32'h0, 32'h0, 16'h0, 32'h10, 1'b1, 32'h0, 6'd22, 1'b0, 32'h0, 32'h0, 1'b0, 8'h0);
      send(OP_JUMP, 32'h0, 32'h0, 16'h0, 32'h20, 1'b1, 32'h0, 6'd23, 1'b0, 32'h0, 32'h0, 1'b0, 8'h0);
      flush_i = 1'b1;
      @(posedge clk);
      #1;
      flush_i = 1'b0;
      out_ready_i = 1'b1;
      n_tests++;
      if (out_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_stages out_valid=%b required 0", out_valid_o);
      end
      wait_drain();
   endtask

   task automatic test_wrap_and_async_reset();
      out_ready_i = 1'b1;
      send(OP_BNE, 32'd1, 32'd0, 16'h0000, 32'h0, 1'b1, 32'hFFFF_FFF8, 6'd30, 1'b1,
           32'h0, 32'h0, 1'b1, 8'hA4);
      wait_drain();
      out_ready_i = 1'b0;
      send(OP_JAL, 32'h0, 32'h0, 16'h0, 32'h55, 1'b1, 32'h800, 6'd31, 1'b0, 32'h0, 32'h0, 1'b0, 8'h0);
      @(posedge clk);
      #1;
      n_tests++;
      if (out_valid_o !== 1'b1 || tag_o !== 6'd31) begin
         n_fail++;
         $display("FAIL pre_reset_hold out_valid=%b tag=%0d required 1 31", out_valid_o, tag_o);
      end
      #2;
      reset = 1'b1;
      #1;
      n_tests++;
      if (out_valid_o !== 1'b0 || result_o !== 32'h0 || nextPC_o !== 32'h0 || flags_o !== 8'h0 ||
          tag_o !== 6'h0 || direction_o !== 1'b0 || redirect_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL async_reset ov=%b res=%h next=%h flags=%h tag=%0d dir=%b rv=%b in_ready=%b required 0s and in_ready 1",
                  out_valid_o, result_o, nextPC_o, flags_o, tag_o, direction_o, redirect_valid_o, in_ready_o);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      out_ready_i = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
   endtask

   initial begin
      test_reset();
      test_bgez_latency();
      test_jumps();
      test_misc_ops();
      test_mispredict_redirect();
      test_back_to_back();
      test_flush();
      test_wrap_and_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
